// File: rtl/seq_ring_accum.sv
// rtl/seq_ring_accum.sv - NCH-channel ring accumulator running a DEPTH-step sequence
//
// Purpose:
//   Holds NCH channel registers of WIDTH bits. A start request in IDLE seeds the
//   channels and latches the combine mode. The block then runs DEPTH steps. On
//   each step every channel is combined with its ring neighbour (k+1, with the
//   last channel wrapping to channel 0). The combine is an add modulo 2^WIDTH or
//   an xor, chosen by the latched mode.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-low
//   start     run request, level-sampled in IDLE only
//   mode      0 = add, 1 = xor; latched when a run starts
//   seed      initial channel values, channel k = seed[k*WIDTH +: WIDTH]
//   ch_out    channel registers, same packing as seed
//   busy      high while a run is in progress
//   done      one-cycle pulse in the cycle after the final step
//   step_cnt  steps completed in the current or last run
module seq_ring_accum #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4,
   parameter int DEPTH = 3,
   parameter int CNTW  = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 mode,
   input  logic [NCH*WIDTH-1:0] seed,
   output logic [NCH*WIDTH-1:0] ch_out,
   output logic                 busy,
   output logic                 done,
   output logic [CNTW-1:0]      step_cnt
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [CNTW-1:0] LAST_STEP = CNTW'(DEPTH - 1);
   localparam logic [CNTW-1:0] ALL_STEPS = CNTW'(DEPTH);

   state_t                      state;
   logic                        mode_q;
   logic [NCH-1:0][WIDTH-1:0]   ch;
   logic [NCH-1:0][WIDTH-1:0]   nxt;

   // Every channel reads only pre-edge values, so all channels update together.
   // Add simply truncates to WIDTH bits, which drops the carry.
   always_comb begin
      nxt = '0;
      for (int k = 0; k < NCH; k++) begin
         if (mode_q)
            nxt[k] = ch[k] ^ ch[(k + 1) % NCH];
         else
            nxt[k] = ch[k] + ch[(k + 1) % NCH];
      end
   end

   assign ch_out = ch;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         ch       <= '0;
         mode_q   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         step_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               // done is only ever high for the single IDLE cycle after a run,
               // so clearing it here gives the one-cycle pulse.
               done <= 1'b0;
               if (start) begin
                  ch       <= seed;
                  mode_q   <= mode;
                  step_cnt <= '0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               ch <= nxt;
               if (step_cnt == LAST_STEP) begin
                  step_cnt <= ALL_STEPS;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= IDLE;
               end else begin
                  step_cnt <= step_cnt + CNTW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
